// File: rtl/read_feeder.sv
// read_feeder: registered responder for the systolic array read-fetch port.
// Optional feature macro PHRED_LUT_EN: priors come from a Phred-indexed ROM instead of the load port.
`ifndef MAX_STRING_LENGTH
`define MAX_STRING_LENGTH 16
`endif
`ifndef NUM_PROCS
`define NUM_PROCS 4
`endif

package read_feeder_pkg;
   localparam int unsigned MAX_LEN = `MAX_STRING_LENGTH;
   localparam int unsigned NPROC   = `NUM_PROCS;
   localparam int unsigned IW      = $clog2(MAX_LEN);
   localparam int unsigned DW      = 64;

   typedef enum logic [2:0] {
      STRING_A    = 3'd0,
      STRING_C    = 3'd1,
      STRING_G    = 3'd2,
      STRING_T    = 3'd3,
      STRING_N    = 3'd4,
      STRING_DASH = 3'd5
   } string_t;

   typedef struct packed {
      string_t                  reference;
      string_t [NPROC-1:0]      exp;
      logic                     valid;
   } reads_t;

   typedef struct packed {
      logic [NPROC-1:0][DW-1:0] match;
      logic [NPROC-1:0][DW-1:0] neq;
      logic                     valid;
   } priors_t;
endpackage

module read_feeder
   import read_feeder_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic          load_valid,
   input  logic [IW-1:0] load_addr,
   input  string_t       load_ref,
   input  string_t       load_exp,
`ifdef PHRED_LUT_EN
   input  logic [5:0]    load_qual,
`else
   input  logic [DW-1:0] load_match,
   input  logic [DW-1:0] load_neq,
`endif
   input  logic          start,
   input  logic [IW-1:0] length_in,
   input  logic [IW-1:0] read_index_x,
   input  logic          read_x_valid,
   input  logic [IW-1:0] read_index_y,
   input  logic          read_y_valid,
   input  logic          complete,
   output reads_t        base_reads,
   output priors_t       prior_reads,
   output logic [IW-1:0] string_length,
   output logic          busy,
   output logic          load_err
);

   typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DONE} state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   string_t       r_ref_mem   [MAX_LEN];
   string_t       r_exp_mem   [MAX_LEN];
   logic [DW-1:0] r_match_mem [MAX_LEN];
   logic [DW-1:0] r_neq_mem   [MAX_LEN];

   reads_t        r_base_reads;
   priors_t       r_prior_reads;
   logic [IW-1:0] r_string_length;
   logic          r_busy;
   logic          r_load_err;

   logic          w_addr_ok;
   logic          w_load_en;
   logic          w_load_bad;
   logic          w_req_bad;
   logic [DW-1:0] w_match_in;
   logic [DW-1:0] w_neq_in;
   logic [IW:0]   w_pos     [NPROC];
   logic [NPROC-1:0] w_lane_ok;

`ifdef PHRED_LUT_EN
   typedef logic [DW-1:0] rom_t [64];

   // Elaboration-time tables: epsilon = 10^(-q/10) and its complement
   function automatic rom_t build_eps_rom();
      rom_t rom;
      for (int q = 0; q < 64; q++) begin
         rom[q] = $realtobits(10.0 ** (-real'(q) / 10.0));
      end
      return rom;
   endfunction

   function automatic rom_t build_match_rom();
      rom_t rom;
      for (int q = 0; q < 64; q++) begin
         rom[q] = $realtobits(1.0 - (10.0 ** (-real'(q) / 10.0)));
      end
      return rom;
   endfunction

   localparam rom_t EPS_ROM   = build_eps_rom();
   localparam rom_t MATCH_ROM = build_match_rom();

   assign w_neq_in   = EPS_ROM[load_qual];
   assign w_match_in = MATCH_ROM[load_qual];
`else
   assign w_neq_in   = load_neq;
   assign w_match_in = load_match;
`endif

   assign w_addr_ok = ({1'b0, load_addr} < (IW+1)'(MAX_LEN));

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and load/request qualification
   always_comb begin
      w_state_nxt = r_state;
      w_load_en   = 1'b0;
      w_load_bad  = 1'b0;
      w_req_bad   = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_load_en  = load_valid && w_addr_ok;
            w_load_bad = load_valid && !w_addr_ok;
            w_req_bad  = read_x_valid || read_y_valid;
            if (start) begin
               w_state_nxt = ST_SERVE;
            end
         end
         ST_SERVE: begin
            w_load_bad = load_valid;
            if (complete) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_load_bad  = load_valid;
            w_req_bad   = read_x_valid || read_y_valid;
            w_state_nxt = ST_LOAD;
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // Lane positions carry an extra bit so the padding test never wraps
   always_comb begin
      for (int unsigned i = 0; i < NPROC; i++) begin
         w_pos[i]     = {1'b0, read_index_y} + (IW+1)'(i);
         w_lane_ok[i] = (w_pos[i] < {1'b0, r_string_length}) &&
                        (w_pos[i] < (IW+1)'(MAX_LEN));
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && w_load_en) begin
         r_ref_mem[load_addr]   <= load_ref;
         r_exp_mem[load_addr]   <= load_exp;
         r_match_mem[load_addr] <= w_match_in;
         r_neq_mem[load_addr]   <= w_neq_in;
      end
   end

   // Registered responses; untargeted fields hold
   always_ff @(posedge clock) begin
      if (reset) begin
         r_base_reads    <= '0;
         r_prior_reads   <= '0;
         r_string_length <= '0;
         r_busy          <= 1'b0;
         r_load_err      <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == ST_SERVE);
         if (w_load_bad || w_req_bad) begin
            r_load_err <= 1'b1;
         end
         if ((r_state == ST_LOAD) && start) begin
            r_string_length <= length_in;
         end
         if (r_state == ST_SERVE) begin
            if (read_x_valid) begin
               r_base_reads.reference <= r_ref_mem[read_index_x];
               r_base_reads.valid     <= 1'b1;
            end
            if (read_y_valid) begin
               for (int unsigned i = 0; i < NPROC; i++) begin
                  if (w_lane_ok[i]) begin
                     r_base_reads.exp[i]    <= r_exp_mem[w_pos[i][IW-1:0]];
                     r_prior_reads.match[i] <= r_match_mem[w_pos[i][IW-1:0]];
                     r_prior_reads.neq[i]   <= r_neq_mem[w_pos[i][IW-1:0]];
                  end else begin
                     r_base_reads.exp[i]    <= STRING_DASH;
                     r_prior_reads.match[i] <= '0;
                     r_prior_reads.neq[i]   <= '0;
                  end
               end
               r_prior_reads.valid <= 1'b1;
            end
         end
         if (r_state == ST_DONE) begin
            r_base_reads.valid  <= 1'b0;
            r_prior_reads.valid <= 1'b0;
         end
      end
   end

   assign base_reads    = r_base_reads;
   assign prior_reads   = r_prior_reads;
   assign string_length = r_string_length;
   assign busy          = r_busy;
   assign load_err      = r_load_err;

endmodule

// File: tb/tb_read_feeder.sv
// tb_read_feeder: scoreboard bench for read_feeder; builds with or without PHRED_LUT_EN.
module tb_read_feeder;
   import read_feeder_pkg::*;

   localparam logic [63:0] D_0_1 = 64'h3FB999999999999A;
   localparam logic [63:0] D_0_9 = 64'h3FECCCCCCCCCCCCD;
   localparam logic [63:0] D_1_0 = 64'h3FF0000000000000;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          load_valid = 1'b0;
   logic [IW-1:0] load_addr = '0;
   string_t       load_ref = STRING_A;
   string_t       load_exp = STRING_A;
`ifdef PHRED_LUT_EN
   logic [5:0]    load_qual = '0;
`else
   logic [63:0]   load_match = '0;
   logic [63:0]   load_neq = '0;
`endif
   logic          start = 1'b0;
   logic [IW-1:0] length_in = '0;
   logic [IW-1:0] read_index_x = '0;
   logic          read_x_valid = 1'b0;
   logic [IW-1:0] read_index_y = '0;
   logic          read_y_valid = 1'b0;
   logic          complete = 1'b0;
   reads_t        base_reads;
   priors_t       prior_reads;
   logic [IW-1:0] string_length;
   logic          busy;
   logic          load_err;

   read_feeder dut (
      .clock(clock), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
      .load_ref(load_ref), .load_exp(load_exp),
`ifdef PHRED_LUT_EN
      .load_qual(load_qual),
`else
      .load_match(load_match), .load_neq(load_neq),
`endif
      .start(start), .length_in(length_in),
      .read_index_x(read_index_x), .read_x_valid(read_x_valid),
      .read_index_y(read_index_y), .read_y_valid(read_y_valid),
      .complete(complete), .base_reads(base_reads), .prior_reads(prior_reads),
      .string_length(string_length), .busy(busy), .load_err(load_err)
   );

   initial forever #5 clock = ~clock;

   typedef struct {
      string   name;
      reads_t  br;
      priors_t pr;
   } sb_item_t;

   sb_item_t    sb[$];
   sb_item_t    it;
   int          checks = 0;
   int          failures = 0;

   reads_t      m_br;
   priors_t     m_pr;
   int          m_len;
   string_t     ref_m   [16];
   string_t     exp_m   [16];
   logic [63:0] match_m [16];
   logic [63:0] neq_m   [16];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_pos(input int p, input string_t r, input string_t e);
      load_valid = 1'b1;
      load_addr  = IW'(p);
      load_ref   = r;
      load_exp   = e;
`ifdef PHRED_LUT_EN
      load_qual  = (p % 2 == 1) ? 6'd10 : 6'd0;
      neq_m[p]   = (p % 2 == 1) ? D_0_1 : D_1_0;
      match_m[p] = (p % 2 == 1) ? D_0_9 : 64'h0;
`else
      load_neq   = $realtobits(real'(p));
      load_match = $realtobits(1.0 - real'(p) / 16.0);
      neq_m[p]   = load_neq;
      match_m[p] = load_match;
`endif
      ref_m[p] = r;
      exp_m[p] = e;
      tick();
      load_valid = 1'b0;
   endtask

   // Drive a request and push the model's next output state
   task automatic req(input string nm, input logic xv, input int xi, input logic yv, input int yi);
      read_x_valid = xv;
      read_index_x = IW'(xi);
      read_y_valid = yv;
      read_index_y = IW'(yi);
      if (xv) begin
         m_br.reference = ref_m[xi];
         m_br.valid     = 1'b1;
      end
      if (yv) begin
         for (int i = 0; i < int'(NPROC); i++) begin
            int p = yi + i;
            if (p < m_len) begin
               m_br.exp[i]   = exp_m[p];
               m_pr.match[i] = match_m[p];
               m_pr.neq[i]   = neq_m[p];
            end else begin
               m_br.exp[i]   = STRING_DASH;
               m_pr.match[i] = '0;
               m_pr.neq[i]   = '0;
            end
         end
         m_pr.valid = 1'b1;
      end
      sb.push_back('{nm, m_br, m_pr});
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      m_br = '0;
      m_pr = '0;
      m_len = 0;
      checks++; if (base_reads !== '0) begin failures++; $display("FAIL reset_base got=%h exp=0", base_reads); end
      checks++; if (prior_reads !== '0) begin failures++; $display("FAIL reset_prior got=%h exp=0", prior_reads); end
      checks++; if (string_length !== '0) begin failures++; $display("FAIL reset_len got=%0d exp=0", string_length); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", load_err); end
   endtask

   task automatic test_load();
      string_t rp[4];
      string_t ep[8];
      rp = '{STRING_A, STRING_C, STRING_G, STRING_T};
      ep = '{STRING_T, STRING_T, STRING_G, STRING_G, STRING_C, STRING_C, STRING_A, STRING_A};
      for (int p = 0; p < 16; p++) begin
         load_pos(p, rp[p % 4], (p < 8) ? ep[p] : STRING_N);
      end
      checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL load_err_clean got=%b exp=0", load_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL load_busy got=%b exp=0", busy); end
   endtask

   task automatic test_start();
      start = 1'b1;
      length_in = IW'(8);
      tick();
      start = 1'b0;
      m_len = 8;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", busy); end
      checks++; if (string_length !== IW'(8)) begin failures++; $display("FAIL start_len got=%0d exp=8", string_length); end
      start = 1'b1;
      length_in = IW'(3);
      tick();
      start = 1'b0;
      checks++; if (string_length !== IW'(8)) begin failures++; $display("FAIL start_ignored got=%0d exp=8", string_length); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_ignored_busy got=%b exp=1", busy); end
   endtask

   task automatic test_x_request();
      int xs[2];
      xs = '{3, 0};
      for (int k = 0; k < 2; k++) begin
         req($sformatf("x%0d", xs[k]), 1'b1, xs[k], 1'b0, 0);
         tick();
         read_x_valid = 1'b0;
         it = sb.pop_front();
         checks++; if (base_reads !== it.br) begin failures++; $display("FAIL %s base got=%h exp=%h", it.name, base_reads, it.br); end
         checks++; if (prior_reads !== it.pr) begin failures++; $display("FAIL %s prior got=%h exp=%h", it.name, prior_reads, it.pr); end
      end
   endtask

   task automatic test_y_request();
      int ys[5];
      ys = '{2, 0, 6, 13, 15};
      for (int k = 0; k < 5; k++) begin
         req($sformatf("y%0d", ys[k]), 1'b0, 0, 1'b1, ys[k]);
         tick();
         read_y_valid = 1'b0;
         it = sb.pop_front();
         checks++; if (base_reads !== it.br) begin failures++; $display("FAIL %s base got=%h exp=%h", it.name, base_reads, it.br); end
         checks++; if (prior_reads !== it.pr) begin failures++; $display("FAIL %s prior got=%h exp=%h", it.name, prior_reads, it.pr); end
      end
   endtask

   task automatic test_back_to_back();
      req("dual_x5_y4", 1'b1, 5, 1'b1, 4);
      tick();
      req("b2b_y1", 1'b0, 0, 1'b1, 1);
      it = sb.pop_front();
      checks++; if (base_reads !== it.br) begin failures++; $display("FAIL %s base got=%h exp=%h", it.name, base_reads, it.br); end
      checks++; if (prior_reads !== it.pr) begin failures++; $display("FAIL %s prior got=%h exp=%h", it.name, prior_reads, it.pr); end
      tick();
      read_x_valid = 1'b0;
      read_y_valid = 1'b0;
      it = sb.pop_front();
      checks++; if (base_reads !== it.br) begin failures++; $display("FAIL %s base got=%h exp=%h", it.name, base_reads, it.br); end
      checks++; if (prior_reads !== it.pr) begin failures++; $display("FAIL %s prior got=%h exp=%h", it.name, prior_reads, it.pr); end
   endtask

   task automatic test_hold();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (base_reads !== m_br) begin failures++; $display("FAIL hold%0d base got=%h exp=%h", k, base_reads, m_br); end
         checks++; if (prior_reads !== m_pr) begin failures++; $display("FAIL hold%0d prior got=%h exp=%h", k, prior_reads, m_pr); end
      end
   endtask

   task automatic test_load_in_serve();
      load_valid = 1'b1;
      load_addr  = IW'(3);
      load_ref   = STRING_A;
      load_exp   = STRING_N;
`ifdef PHRED_LUT_EN
      load_qual  = 6'd30;
`else
      load_neq   = 64'hDEAD_BEEF_0000_0001;
      load_match = 64'hDEAD_BEEF_0000_0002;
`endif
      tick();
      load_valid = 1'b0;
      checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL serve_load_err got=%b exp=1", load_err); end
      req("after_drop_x3_y3", 1'b1, 3, 1'b1, 3);
      tick();
      read_x_valid = 1'b0;
      read_y_valid = 1'b0;
      it = sb.pop_front();
      checks++; if (base_reads !== it.br) begin failures++; $display("FAIL %s base got=%h exp=%h", it.name, base_reads, it.br); end
      checks++; if (prior_reads !== it.pr) begin failures++; $display("FAIL %s prior got=%h exp=%h", it.name, prior_reads, it.pr); end
   endtask

   task automatic test_complete();
      complete = 1'b1;
      tick();
      complete = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_busy got=%b exp=0", busy); end
      checks++; if (base_reads !== m_br) begin failures++; $display("FAIL done_hold_base got=%h exp=%h", base_reads, m_br); end
      checks++; if (prior_reads !== m_pr) begin failures++; $display("FAIL done_hold_prior got=%h exp=%h", prior_reads, m_pr); end
      tick();
      m_br.valid = 1'b0;
      m_pr.valid = 1'b0;
      checks++; if (base_reads !== m_br) begin failures++; $display("FAIL load_clr_base got=%h exp=%h", base_reads, m_br); end
      checks++; if (prior_reads !== m_pr) begin failures++; $display("FAIL load_clr_prior got=%h exp=%h", prior_reads, m_pr); end
      checks++; if (string_length !== IW'(8)) begin failures++; $display("FAIL load_len_hold got=%0d exp=8", string_length); end
   endtask

   task automatic test_req_outside_serve();
      test_reset();
      read_x_valid = 1'b1;
      read_index_x = IW'(2);
      tick();
      read_x_valid = 1'b0;
      checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL load_req_err got=%b exp=1", load_err); end
      checks++; if (base_reads !== '0) begin failures++; $display("FAIL load_req_ignored got=%h exp=0", base_reads); end
      start = 1'b1;
      length_in = IW'(8);
      tick();
      start = 1'b0;
      m_len = 8;
      req("kept_x3", 1'b1, 3, 1'b0, 0);
      tick();
      read_x_valid = 1'b0;
      it = sb.pop_front();
      checks++; if (base_reads !== it.br) begin failures++; $display("FAIL %s base got=%h exp=%h", it.name, base_reads, it.br); end
   endtask

   task automatic test_reset_mid_serve();
      read_x_valid = 1'b1;
      read_index_x = IW'(1);
      read_y_valid = 1'b1;
      read_index_y = IW'(1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      read_x_valid = 1'b0;
      read_y_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_serve_busy got=%b exp=0", busy); end
      checks++; if (base_reads !== '0) begin failures++; $display("FAIL rst_serve_base got=%h exp=0", base_reads); end
      checks++; if (prior_reads !== '0) begin failures++; $display("FAIL rst_serve_prior got=%h exp=0", prior_reads); end
      checks++; if (string_length !== '0) begin failures++; $display("FAIL rst_serve_len got=%0d exp=0", string_length); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_start();
      test_x_request();
      test_y_request();
      test_back_to_back();
      test_hold();
      test_load_in_serve();
      test_complete();
      test_req_outside_serve();
      test_reset_mid_serve();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
